// File: rtl/wb_spram_bridge_if.sv
`default_nettype none
// ============================================================================
// wb_spram_bridge_if : Wishbone B4 pipelined bus bundle for wb_spram_bridge
// Revision: 1.0
// ============================================================================
interface wb_spram_bridge_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_we_i;
  logic [ADDR_WIDTH-1:0]   wb_adr_i;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [DATA_WIDTH/8-1:0] wb_sel_i;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic                    wb_ack_o;
  logic                    wb_stall_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_spram_bridge.sv
`default_nettype none
// ============================================================================
// wb_spram_bridge : Wishbone B4 pipelined slave in front of a 1-cycle SPRAM,
//                   byte writes done as read-modify-write with one stall cycle
// Revision: 1.0
// ============================================================================
module wb_spram_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  wb_spram_bridge_if.slave           wb,
  output logic [ADDR_WIDTH-1:0]      ram_address,
  output logic [DATA_WIDTH-1:0]      ram_data,
  input  wire logic [DATA_WIDTH-1:0] ram_q,
  output logic                       ram_wren,
  output logic                       ram_cen
);

  localparam int c_LANES = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_MERGE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [c_LANES-1:0]    sel_q, sel_d;

  logic                  w_accept;
  logic                  w_sel_full;
  logic                  w_sel_none;
  logic                  w_partial;
  logic [DATA_WIDTH-1:0] w_merge_data;

  // Acceptance only ever happens in IDLE, so it is derived from state, not stall.
  assign w_accept   = wb.wb_cyc_i & wb.wb_stb_i & (state_q == S_IDLE) & ~reset;
  assign w_sel_full = &wb.wb_sel_i;
  assign w_sel_none = ~|wb.wb_sel_i;
  assign w_partial  = w_accept & wb.wb_we_i & ~w_sel_full & ~w_sel_none;

  for (genvar g = 0; g < c_LANES; g++) begin : g_lane
    assign w_merge_data[g*8 +: 8] = sel_q[g] ? dat_q[g*8 +: 8] : ram_q[g*8 +: 8];
  end

  assign wb.wb_stall_o = (state_q == S_MERGE) & ~reset;
  assign wb.wb_ack_o   = ack_q & wb.wb_cyc_i & ~reset;
  assign wb.wb_dat_o   = (wb.wb_ack_o & rd_q) ? ram_q : '0;

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    rd_d        = 1'b0;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    ram_address = wb.wb_adr_i;
    ram_data    = wb.wb_dat_i;
    ram_cen     = 1'b0;
    ram_wren    = 1'b0;

    case (state_q)
      S_IDLE: begin
        ram_cen  = w_accept & ~(wb.wb_we_i & w_sel_none);
        ram_wren = w_accept & wb.wb_we_i & w_sel_full;
        if (w_partial) begin
          state_d = S_MERGE;
          adr_d   = wb.wb_adr_i;
          dat_d   = wb.wb_dat_i;
          sel_d   = wb.wb_sel_i;
        end else if (w_accept) begin
          ack_d = 1'b1;
          rd_d  = ~wb.wb_we_i;
        end
      end
      S_MERGE: begin
        // The merged write always lands; only its ack depends on the cycle staying open.
        ram_address = adr_q;
        ram_data    = w_merge_data;
        ram_cen     = 1'b1;
        ram_wren    = 1'b1;
        state_d     = S_IDLE;
        ack_d       = wb.wb_cyc_i;
      end
      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      ram_cen  = 1'b0;
      ram_wren = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_spram_bridge.sv
`default_nettype none
// ============================================================================
// tb_wb_spram_bridge : directed and randomized checks of wb_spram_bridge
// Revision: 1.0
// ============================================================================
module tb_wb_spram_bridge;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  logic          ram_wren;
  logic          ram_cen;
  logic          mem_clear;

  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  int n_checks;
  int n_fail;

  always #5 clock = ~clock;

  wb_spram_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  wb_spram_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .wb          (wb.slave),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_q       (ram_q),
    .ram_wren    (ram_wren),
    .ram_cen     (ram_cen)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      ram_q <= '0;
    end else if (ram_cen) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= mem[ram_address];
    end
  end

  task automatic drive_req(input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [1:0] sel);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = sel;
  endtask

  task automatic drive_idle(input logic cyc);
    wb.wb_cyc_i = cyc;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    wb.wb_sel_i = '0;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    mem_clear = 1'b1;
    drive_req(1'b1, 12'h2A5, 16'h1357, 2'b11);
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", wb.wb_ack_o); end
    n_checks++; if (wb.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", wb.wb_stall_o); end
    n_checks++; if (wb.wb_dat_o !== 16'h0) begin n_fail++; $display("FAIL rst_dat: got %h want 0000", wb.wb_dat_o); end
    n_checks++; if (ram_cen !== 1'b0) begin n_fail++; $display("FAIL rst_cen: got %b want 0", ram_cen); end
    n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %b want 0", ram_wren); end
    n_checks++; if (ram_address !== 12'h2A5) begin n_fail++; $display("FAIL rst_addr: got %h want 2a5", ram_address); end
    n_checks++; if (ram_data !== 16'h1357) begin n_fail++; $display("FAIL rst_data: got %h want 1357", ram_data); end
    step;
    mem_clear = 1'b0;
    drive_idle(1'b1);
    step;
    reset = 1'b0;
    drive_req(1'b0, 12'h000, 16'h0, 2'b11);
    @(negedge clock);
    n_checks++; if (ram_cen !== 1'b1 || ram_wren !== 1'b0) begin n_fail++; $display("FAIL rd0_strobe: got cen=%b wren=%b want cen=1 wren=0", ram_cen, ram_wren); end
    step;
    drive_idle(1'b1);
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL rd0_ack: got %b want 1", wb.wb_ack_o); end
    n_checks++; if (wb.wb_dat_o !== 16'h0) begin n_fail++; $display("FAIL rd0_dat: got %h want 0000", wb.wb_dat_o); end
    step;
  endtask

  task automatic test_full_write_read;
    drive_req(1'b1, 12'h123, 16'hBEEF, 2'b11);
    @(negedge clock);
    n_checks++; if (wb.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL fw_stall: got %b want 0", wb.wb_stall_o); end
    n_checks++; if (ram_cen !== 1'b1 || ram_wren !== 1'b1) begin n_fail++; $display("FAIL fw_strobe: got cen=%b wren=%b want 1 1", ram_cen, ram_wren); end
    step;
    drive_req(1'b0, 12'h123, 16'h0, 2'b11);
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL fw_ack: got %b want 1", wb.wb_ack_o); end
    n_checks++; if (wb.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL fwr_stall: got %b want 0", wb.wb_stall_o); end
    n_checks++; if (wb.wb_dat_o !== 16'h0) begin n_fail++; $display("FAIL fw_ackdat: got %h want 0000", wb.wb_dat_o); end
    step;
    drive_idle(1'b1);
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL fwr_ack: got %b want 1", wb.wb_ack_o); end
    n_checks++; if (wb.wb_dat_o !== 16'hBEEF) begin n_fail++; $display("FAIL fwr_dat: got %h want beef", wb.wb_dat_o); end
    step;
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL fwr_noack: got %b want 0", wb.wb_ack_o); end
    step;
  endtask

  task automatic test_partial;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic [15:0] exp;
    drive_req(1'b1, 12'h010, 16'h1234, 2'b11);
    @(negedge clock);
    step;
    drive_idle(1'b1);
    @(negedge clock);
    step;
    for (int k = 0; k < 2; k++) begin
      sel = (k == 0) ? 2'b10 : 2'b01;
      dat = (k == 0) ? 16'hAB00 : 16'h00CD;
      exp = (k == 0) ? 16'hAB34 : 16'hABCD;
      drive_req(1'b1, 12'h010, dat, sel);
      @(negedge clock);
      n_checks++; if (wb.wb_stall_o !== 1'b0 || ram_cen !== 1'b1 || ram_wren !== 1'b0) begin n_fail++; $display("FAIL pw%0d_accept: got stall=%b cen=%b wren=%b want 0 1 0", k, wb.wb_stall_o, ram_cen, ram_wren); end
      step;
      drive_idle(1'b1);
      @(negedge clock);
      n_checks++; if (wb.wb_stall_o !== 1'b1) begin n_fail++; $display("FAIL pw%0d_stall: got %b want 1", k, wb.wb_stall_o); end
      n_checks++; if (ram_wren !== 1'b1 || ram_cen !== 1'b1) begin n_fail++; $display("FAIL pw%0d_wren: got cen=%b wren=%b want 1 1", k, ram_cen, ram_wren); end
      n_checks++; if (ram_address !== 12'h010) begin n_fail++; $display("FAIL pw%0d_addr: got %h want 010", k, ram_address); end
      n_checks++; if (ram_data !== exp) begin n_fail++; $display("FAIL pw%0d_merge: got %h want %h", k, ram_data, exp); end
      n_checks++; if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL pw%0d_earlyack: got %b want 0", k, wb.wb_ack_o); end
      step;
      @(negedge clock);
      n_checks++; if (wb.wb_ack_o !== 1'b1 || wb.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL pw%0d_ack: got ack=%b stall=%b want 1 0", k, wb.wb_ack_o, wb.wb_stall_o); end
      step;
      drive_req(1'b0, 12'h010, 16'h0, 2'b11);
      @(negedge clock);
      step;
      drive_idle(1'b1);
      @(negedge clock);
      n_checks++; if (wb.wb_ack_o !== 1'b1 || wb.wb_dat_o !== exp) begin n_fail++; $display("FAIL pw%0d_readback: got ack=%b dat=%h want 1 %h", k, wb.wb_ack_o, wb.wb_dat_o, exp); end
      step;
    end
  endtask

  typedef struct packed {
    logic        vld;
    logic        we;
    logic [11:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        ack;
    logic [15:0] rdat;
    logic        stall;
  } row_t;

  task automatic test_back_to_back;
    row_t tbl [0:10];
    tbl[0]  = '{1'b1, 1'b1, 12'h000, 16'h1111, 2'b11, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 12'h001, 16'h2222, 2'b11, 1'b1, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 12'hFFF, 16'h3333, 2'b11, 1'b1, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 12'h000, 16'h0000, 2'b11, 1'b1, 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 12'h001, 16'h0000, 2'b11, 1'b1, 16'h1111, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 2'b11, 1'b1, 16'h2222, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 12'h005, 16'h00EE, 2'b01, 1'b1, 16'h3333, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 12'h001, 16'h0000, 2'b11, 1'b0, 16'h0000, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 12'h001, 16'h0000, 2'b11, 1'b1, 16'h0000, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 12'h000, 16'h0000, 2'b00, 1'b1, 16'h2222, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 12'h000, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0};
    for (int c = 0; c < 11; c++) begin
      if (tbl[c].vld) drive_req(tbl[c].we, tbl[c].adr, tbl[c].dat, tbl[c].sel);
      else            drive_idle(1'b1);
      @(negedge clock);
      n_checks++; if (wb.wb_ack_o !== tbl[c].ack) begin n_fail++; $display("FAIL b2b%0d_ack: got %b want %b", c, wb.wb_ack_o, tbl[c].ack); end
      n_checks++; if (wb.wb_dat_o !== tbl[c].rdat) begin n_fail++; $display("FAIL b2b%0d_dat: got %h want %h", c, wb.wb_dat_o, tbl[c].rdat); end
      n_checks++; if (wb.wb_stall_o !== tbl[c].stall) begin n_fail++; $display("FAIL b2b%0d_stall: got %b want %b", c, wb.wb_stall_o, tbl[c].stall); end
      step;
    end
  endtask

  task automatic test_sel00;
    drive_req(1'b1, 12'h030, 16'h5A5A, 2'b11);
    @(negedge clock);
    step;
    drive_req(1'b1, 12'h030, 16'hFFFF, 2'b00);
    @(negedge clock);
    n_checks++; if (ram_cen !== 1'b0 || ram_wren !== 1'b0) begin n_fail++; $display("FAIL s00_strobe: got cen=%b wren=%b want 0 0", ram_cen, ram_wren); end
    n_checks++; if (wb.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL s00_stall: got %b want 0", wb.wb_stall_o); end
    step;
    drive_idle(1'b1);
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b1 || wb.wb_dat_o !== 16'h0) begin n_fail++; $display("FAIL s00_ack: got ack=%b dat=%h want 1 0000", wb.wb_ack_o, wb.wb_dat_o); end
    step;
    drive_req(1'b0, 12'h030, 16'h0, 2'b11);
    @(negedge clock);
    step;
    drive_idle(1'b1);
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b1 || wb.wb_dat_o !== 16'h5A5A) begin n_fail++; $display("FAIL s00_readback: got ack=%b dat=%h want 1 5a5a", wb.wb_ack_o, wb.wb_dat_o); end
    step;
  endtask

  task automatic test_cyc_drop;
    drive_req(1'b1, 12'h020, 16'h7777, 2'b11);
    @(negedge clock);
    step;
    drive_req(1'b1, 12'h020, 16'h1200, 2'b10);
    @(negedge clock);
    step;
    drive_idle(1'b0);
    @(negedge clock);
    n_checks++; if (ram_wren !== 1'b1 || ram_data !== 16'h1277 || ram_address !== 12'h020) begin n_fail++; $display("FAIL cdrop_write: got wren=%b data=%h addr=%h want 1 1277 020", ram_wren, ram_data, ram_address); end
    step;
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL cdrop_ack: got %b want 0", wb.wb_ack_o); end
    step;
    drive_idle(1'b1);
    step;
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL cdrop_lateack: got %b want 0", wb.wb_ack_o); end
    step;
    drive_req(1'b0, 12'h020, 16'h0, 2'b11);
    @(negedge clock);
    step;
    drive_idle(1'b1);
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b1 || wb.wb_dat_o !== 16'h1277) begin n_fail++; $display("FAIL cdrop_readback: got ack=%b dat=%h want 1 1277", wb.wb_ack_o, wb.wb_dat_o); end
    step;
  endtask

  task automatic test_reset_merge;
    drive_req(1'b1, 12'h021, 16'h4444, 2'b11);
    @(negedge clock);
    step;
    drive_req(1'b1, 12'h021, 16'h0099, 2'b01);
    @(negedge clock);
    step;
    drive_idle(1'b1);
    @(negedge clock);
    n_checks++; if (ram_wren !== 1'b1) begin n_fail++; $display("FAIL rmrg_pre: got wren=%b want 1", ram_wren); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (ram_wren !== 1'b0 || ram_cen !== 1'b0) begin n_fail++; $display("FAIL rmrg_strobe: got cen=%b wren=%b want 0 0", ram_cen, ram_wren); end
    n_checks++; if (wb.wb_stall_o !== 1'b0 || wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rmrg_bus: got stall=%b ack=%b want 0 0", wb.wb_stall_o, wb.wb_ack_o); end
    step;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b0 || wb.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL rmrg_after: got ack=%b stall=%b want 0 0", wb.wb_ack_o, wb.wb_stall_o); end
    step;
    drive_req(1'b0, 12'h021, 16'h0, 2'b11);
    @(negedge clock);
    step;
    drive_idle(1'b1);
    @(negedge clock);
    n_checks++; if (wb.wb_ack_o !== 1'b1 || wb.wb_dat_o !== 16'h4444) begin n_fail++; $display("FAIL rmrg_readback: got ack=%b dat=%h want 1 4444", wb.wb_ack_o, wb.wb_dat_o); end
    step;
  endtask

  // Transaction-level model: acks one cycle after acceptance (two for byte
  // writes, which stall the cycle in between); reads see all earlier writes.
  task automatic test_random;
    bit          have_req;
    bit          in_merge;
    bit          nxt_merge;
    logic        r_we;
    logic [11:0] r_adr;
    logic [15:0] r_dat;
    logic [1:0]  r_sel;
    int          pend;
    logic [15:0] pend_dat;
    logic [15:0] mask;
    logic [15:0] exp_dat;
    have_req = 0; in_merge = 0; pend = 0; pend_dat = '0;
    r_we = 0; r_adr = '0; r_dat = '0; r_sel = '0;
    for (int c = 0; c < 400; c++) begin
      if (!have_req && $urandom_range(0, 3) != 0) begin
        have_req = 1;
        r_adr = 12'h100 + 12'($urandom_range(0, 15));
        r_dat = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       begin r_we = 1'b0; r_sel = 2'($urandom); end
          1:       begin r_we = 1'b1; r_sel = 2'b11; end
          2:       begin r_we = 1'b1; r_sel = 2'b00; end
          default: begin r_we = 1'b1; r_sel = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10; end
        endcase
      end
      if (have_req) drive_req(r_we, r_adr, r_dat, r_sel);
      else          drive_idle(1'b1);
      @(negedge clock);
      exp_dat = (pend == 2) ? pend_dat : 16'h0;
      n_checks++; if (wb.wb_stall_o !== in_merge) begin n_fail++; $display("FAIL rnd%0d_stall: got %b want %b", c, wb.wb_stall_o, in_merge); end
      n_checks++; if (wb.wb_ack_o !== (pend != 0)) begin n_fail++; $display("FAIL rnd%0d_ack: got %b want %b", c, wb.wb_ack_o, (pend != 0)); end
      n_checks++; if (wb.wb_dat_o !== exp_dat) begin n_fail++; $display("FAIL rnd%0d_dat: got %h want %h", c, wb.wb_dat_o, exp_dat); end
      nxt_merge = 0;
      if (in_merge) begin
        pend = 1;
      end else if (have_req) begin
        have_req = 0;
        if (!r_we) begin
          pend = 2;
          pend_dat = ref_mem[r_adr];
        end else if (r_sel == 2'b11) begin
          pend = 1;
          ref_mem[r_adr] = r_dat;
        end else if (r_sel == 2'b00) begin
          pend = 1;
        end else begin
          mask = {{8{r_sel[1]}}, {8{r_sel[0]}}};
          ref_mem[r_adr] = (r_dat & mask) | (ref_mem[r_adr] & ~mask);
          pend = 0;
          nxt_merge = 1;
        end
      end else begin
        pend = 0;
      end
      in_merge = nxt_merge;
      step;
    end
    drive_idle(1'b1);
    repeat (3) step;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    mem_clear = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    drive_idle(1'b0);
    test_reset;
    test_full_write_read;
    test_partial;
    test_back_to_back;
    test_sel00;
    test_cyc_drop;
    test_reset_merge;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
